// File: rtl/cp0_ctrl.sv
// Coprocessor 0: SR/Cause/EPC/PRId registers, interrupt and exception request generation,
// mfc0/mtc0 access and eret EXL clearing.
module cp0_ctrl #(
   parameter logic [31:0] PRID_VAL = 32'h2022_0707
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  A1,
   input  logic [4:0]  A2,
   input  logic [31:0] DIn,
   input  logic        WE,
   input  logic [31:0] PC_M,
   input  logic        BD_M,
   input  logic [4:0]  ExcCode_M,
   input  logic [5:0]  HWInt,
   input  logic        EXLClr,
   output logic        Req,
   output logic [31:0] DOut,
   output logic [31:0] EPC_O
);

   localparam logic [4:0] RegSr   = 5'd12;
   localparam logic [4:0] RegCause = 5'd13;
   localparam logic [4:0] RegEpc  = 5'd14;
   localparam logic [4:0] RegPrid = 5'd15;

   logic [5:0]  im_q, im_d;
   logic        exl_q, exl_d;
   logic        ie_q, ie_d;
   logic        bd_q, bd_d;
   logic [5:0]  ip_q, ip_d;
   logic [4:0]  exc_code_q, exc_code_d;
   logic [31:2] epc_q, epc_d;

   logic        int_req;
   logic        exc_req;
   logic [31:0] epc_next;
   logic [31:0] sr_val;
   logic [31:0] cause_val;
   logic [31:0] epc_val;
   logic        unused_epc_low;

   assign int_req = (|(HWInt & im_q)) & ie_q & ~exl_q;
   assign exc_req = (ExcCode_M != 5'd0) & ~exl_q;
   assign Req     = (int_req | exc_req) & ~reset;

   // Delay-slot instructions restart at the branch; subtraction wraps modulo 2^32.
   assign epc_next       = BD_M ? (PC_M - 32'd4) : PC_M;
   assign unused_epc_low = ^epc_next[1:0];

   assign sr_val    = {16'h0000, im_q, 8'h00, exl_q, ie_q};
   assign cause_val = {bd_q, 15'h0000, ip_q, 3'b000, exc_code_q, 2'b00};
   assign epc_val   = {epc_q, 2'b00};
   assign EPC_O     = epc_val;

   always_comb begin
      im_d       = im_q;
      exl_d      = exl_q;
      ie_d       = ie_q;
      bd_d       = bd_q;
      ip_d       = HWInt;
      exc_code_d = exc_code_q;
      epc_d      = epc_q;
      if (Req) begin
         exl_d      = 1'b1;
         bd_d       = BD_M;
         exc_code_d = int_req ? 5'd0 : ExcCode_M;
         epc_d      = epc_next[31:2];
      end else begin
         if (WE) begin
            case (A2)
               RegSr: begin
                  im_d  = DIn[15:10];
                  exl_d = DIn[1];
                  ie_d  = DIn[0];
               end
               RegEpc:  epc_d = DIn[31:2];
               default: ;
            endcase
         end
         // eret overrides an mtc0 to SR for the EXL bit only.
         if (EXLClr) exl_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         im_q       <= 6'd0;
         exl_q      <= 1'b0;
         ie_q       <= 1'b0;
         bd_q       <= 1'b0;
         ip_q       <= 6'd0;
         exc_code_q <= 5'd0;
         epc_q      <= 30'd0;
      end else begin
         im_q       <= im_d;
         exl_q      <= exl_d;
         ie_q       <= ie_d;
         bd_q       <= bd_d;
         ip_q       <= ip_d;
         exc_code_q <= exc_code_d;
         epc_q      <= epc_d;
      end
   end

   always_comb begin
      DOut = 32'd0;
      case (A1)
         RegSr:    DOut = sr_val;
         RegCause: DOut = cause_val;
         RegEpc:   DOut = epc_val;
         RegPrid:  DOut = PRID_VAL;
         default:  DOut = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_cp0_ctrl.sv
// Directed self-checking bench for cp0_ctrl: reset, exceptions, interrupts, mtc0/eret interplay.
module tb_cp0_ctrl;

   logic        clk;
   logic        reset;
   logic [4:0]  A1;
   logic [4:0]  A2;
   logic [31:0] DIn;
   logic        WE;
   logic [31:0] PC_M;
   logic        BD_M;
   logic [4:0]  ExcCode_M;
   logic [5:0]  HWInt;
   logic        EXLClr;
   logic        Req;
   logic [31:0] DOut;
   logic [31:0] EPC_O;

   int errors = 0;
   int checks = 0;

   cp0_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .A1        (A1),
      .A2        (A2),
      .DIn       (DIn),
      .WE        (WE),
      .PC_M      (PC_M),
      .BD_M      (BD_M),
      .ExcCode_M (ExcCode_M),
      .HWInt     (HWInt),
      .EXLClr    (EXLClr),
      .Req       (Req),
      .DOut      (DOut),
      .EPC_O     (EPC_O)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      ExcCode_M = 5'd4;
      #1;
      checks++; if (Req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", Req); end
      A1 = 5'd12; #1;
      checks++; if (DOut !== 32'h0) begin errors++; $display("FAIL reset_sr got=%h exp=0", DOut); end
      A1 = 5'd13; #1;
      checks++; if (DOut !== 32'h0) begin errors++; $display("FAIL reset_cause got=%h exp=0", DOut); end
      checks++; if (EPC_O !== 32'h0) begin errors++; $display("FAIL reset_epc got=%h exp=0", EPC_O); end
      A1 = 5'd15; #1;
      checks++; if (DOut !== 32'h2022_0707) begin errors++; $display("FAIL prid got=%h exp=20220707", DOut); end
      A1 = 5'd3; #1;
      checks++; if (DOut !== 32'h0) begin errors++; $display("FAIL read_other got=%h exp=0", DOut); end
      @(negedge clk);
      ExcCode_M = 5'd0;
      reset = 1'b0;
      step();
      checks++; if (Req !== 1'b0) begin errors++; $display("FAIL post_reset_req got=%b exp=0", Req); end
   endtask

   task automatic test_exception();
      @(negedge clk);
      ExcCode_M = 5'd4; PC_M = 32'h3010; BD_M = 1'b0; A1 = 5'd13;
      #1;
      checks++; if (Req !== 1'b1) begin errors++; $display("FAIL exc_req got=%b exp=1", Req); end
      step();
      checks++; if (EPC_O !== 32'h3010) begin errors++; $display("FAIL exc_epc got=%h exp=3010", EPC_O); end
      checks++; if (DOut !== 32'h10) begin errors++; $display("FAIL exc_cause got=%h exp=10", DOut); end
      checks++; if (Req !== 1'b0) begin errors++; $display("FAIL exc_req_drop got=%b exp=0", Req); end
      A1 = 5'd12; #1;
      checks++; if (DOut !== 32'h2) begin errors++; $display("FAIL exc_sr got=%h exp=2", DOut); end
      @(negedge clk);
      ExcCode_M = 5'd0; EXLClr = 1'b1;
      step();
      EXLClr = 1'b0;
      checks++; if (DOut !== 32'h0) begin errors++; $display("FAIL exc_eret_sr got=%h exp=0", DOut); end
   endtask

   task automatic test_interrupt();
      @(negedge clk);
      WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0401; A1 = 5'd12;
      step();
      WE = 1'b0;
      checks++; if (DOut !== 32'h401) begin errors++; $display("FAIL int_sr_write got=%h exp=401", DOut); end
      checks++; if (Req !== 1'b0) begin errors++; $display("FAIL int_idle_req got=%b exp=0", Req); end
      @(negedge clk);
      HWInt = 6'b000001; PC_M = 32'h3020;
      #1;
      checks++; if (Req !== 1'b1) begin errors++; $display("FAIL int_req got=%b exp=1", Req); end
      step();
      checks++; if (DOut !== 32'h403) begin errors++; $display("FAIL int_sr got=%h exp=403", DOut); end
      checks++; if (EPC_O !== 32'h3020) begin errors++; $display("FAIL int_epc got=%h exp=3020", EPC_O); end
      A1 = 5'd13; #1;
      checks++; if (DOut !== 32'h400) begin errors++; $display("FAIL int_cause got=%h exp=400", DOut); end
      @(negedge clk);
      HWInt = 6'b0; EXLClr = 1'b1; A1 = 5'd12;
      step();
      EXLClr = 1'b0;
      checks++; if (DOut !== 32'h401) begin errors++; $display("FAIL int_eret_sr got=%h exp=401", DOut); end
   endtask

   task automatic test_delay_slot();
      @(negedge clk);
      BD_M = 1'b1; PC_M = 32'h3004; ExcCode_M = 5'd10; A1 = 5'd13;
      #1;
      checks++; if (Req !== 1'b1) begin errors++; $display("FAIL bd_req got=%b exp=1", Req); end
      step();
      checks++; if (EPC_O !== 32'h3000) begin errors++; $display("FAIL bd_epc got=%h exp=3000", EPC_O); end
      checks++; if (DOut !== 32'h8000_0028) begin errors++; $display("FAIL bd_cause got=%h exp=80000028", DOut); end
      @(negedge clk);
      BD_M = 1'b0; ExcCode_M = 5'd0; EXLClr = 1'b1;
      step();
      @(negedge clk);
      EXLClr = 1'b0; BD_M = 1'b1; PC_M = 32'h0; ExcCode_M = 5'd4;
      step();
      checks++; if (EPC_O !== 32'hFFFF_FFFC) begin errors++; $display("FAIL bd_wrap got=%h exp=fffffffc", EPC_O); end
      @(negedge clk);
      BD_M = 1'b0; ExcCode_M = 5'd0; EXLClr = 1'b1;
      step();
      EXLClr = 1'b0;
   endtask

   task automatic test_priority();
      @(negedge clk);
      HWInt = 6'b000001; ExcCode_M = 5'd12; PC_M = 32'h4000; A1 = 5'd13;
      #1;
      checks++; if (Req !== 1'b1) begin errors++; $display("FAIL prio_req got=%b exp=1", Req); end
      step();
      checks++; if (DOut !== 32'h400) begin errors++; $display("FAIL prio_cause got=%h exp=400", DOut); end
      checks++; if (EPC_O !== 32'h4000) begin errors++; $display("FAIL prio_epc got=%h exp=4000", EPC_O); end
      @(negedge clk);
      HWInt = 6'b0; ExcCode_M = 5'd0; EXLClr = 1'b1;
      step();
      EXLClr = 1'b0;
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      ExcCode_M = 5'd4; PC_M = 32'h5008; WE = 1'b1; A2 = 5'd14; DIn = 32'h1237; A1 = 5'd14;
      #1;
      checks++; if (DOut !== 32'h4000) begin errors++; $display("FAIL b2b_pre_read got=%h exp=4000", DOut); end
      checks++; if (Req !== 1'b1) begin errors++; $display("FAIL b2b_req got=%b exp=1", Req); end
      step();
      checks++; if (EPC_O !== 32'h5008) begin errors++; $display("FAIL b2b_write_dropped got=%h exp=5008", EPC_O); end
      @(negedge clk);
      ExcCode_M = 5'd0; EXLClr = 1'b1;
      #1;
      checks++; if (Req !== 1'b0) begin errors++; $display("FAIL b2b_masked_req got=%b exp=0", Req); end
      checks++; if (DOut !== 32'h5008) begin errors++; $display("FAIL b2b_no_writethru got=%h exp=5008", DOut); end
      step();
      checks++; if (EPC_O !== 32'h1234) begin errors++; $display("FAIL b2b_epc_write got=%h exp=1234", EPC_O); end
      A1 = 5'd12; #1;
      checks++; if (DOut !== 32'h401) begin errors++; $display("FAIL b2b_sr got=%h exp=401", DOut); end
      @(negedge clk);
      WE = 1'b0; EXLClr = 1'b0;
   endtask

   task automatic test_exlclr();
      @(negedge clk);
      HWInt = 6'b000001; PC_M = 32'h6000; A1 = 5'd12;
      step();
      checks++; if (DOut !== 32'h403) begin errors++; $display("FAIL exl_set got=%h exp=403", DOut); end
      checks++; if (Req !== 1'b0) begin errors++; $display("FAIL exl_masks got=%b exp=0", Req); end
      @(negedge clk);
      EXLClr = 1'b1;
      #1;
      checks++; if (Req !== 1'b0) begin errors++; $display("FAIL exl_clr_pre got=%b exp=0", Req); end
      step();
      checks++; if (DOut !== 32'h401) begin errors++; $display("FAIL exl_cleared got=%h exp=401", DOut); end
      checks++; if (Req !== 1'b1) begin errors++; $display("FAIL exl_pending_req got=%b exp=1", Req); end
      @(negedge clk);
      EXLClr = 1'b0;
      step();
      checks++; if (DOut !== 32'h403) begin errors++; $display("FAIL exl_retaken got=%h exp=403", DOut); end
   endtask

   task automatic test_sr_write();
      @(negedge clk);
      HWInt = 6'b0; WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_8403; EXLClr = 1'b1;
      step();
      checks++; if (DOut !== 32'h8401) begin errors++; $display("FAIL sr_eret_wins got=%h exp=8401", DOut); end
      @(negedge clk);
      A2 = 5'd13; DIn = 32'hFFFF_FFFF; EXLClr = 1'b0; A1 = 5'd13;
      step();
      checks++; if (DOut !== 32'h0) begin errors++; $display("FAIL cause_ro got=%h exp=0", DOut); end
      @(negedge clk);
      A2 = 5'd15; A1 = 5'd15;
      step();
      checks++; if (DOut !== 32'h2022_0707) begin errors++; $display("FAIL prid_ro got=%h exp=20220707", DOut); end
      @(negedge clk);
      WE = 1'b0;
   endtask

   task automatic test_reset_mid_exc();
      @(negedge clk);
      ExcCode_M = 5'd8; PC_M = 32'h7000; A1 = 5'd12;
      step();
      checks++; if (DOut !== 32'h8403) begin errors++; $display("FAIL mid_exc_sr got=%h exp=8403", DOut); end
      #2 reset = 1'b1;
      #1;
      checks++; if (EPC_O !== 32'h0) begin errors++; $display("FAIL mid_reset_epc got=%h exp=0", EPC_O); end
      checks++; if (DOut !== 32'h0) begin errors++; $display("FAIL mid_reset_sr got=%h exp=0", DOut); end
      checks++; if (Req !== 1'b0) begin errors++; $display("FAIL mid_reset_req got=%b exp=0", Req); end
      @(negedge clk);
      ExcCode_M = 5'd0; reset = 1'b0;
      step();
      checks++; if (Req !== 1'b0) begin errors++; $display("FAIL mid_reset_after got=%b exp=0", Req); end
   endtask

   initial begin
      reset = 1'b1; A1 = 5'd0; A2 = 5'd0; DIn = 32'h0; WE = 1'b0; PC_M = 32'h0;
      BD_M = 1'b0; ExcCode_M = 5'd0; HWInt = 6'b0; EXLClr = 1'b0;
      repeat (2) @(posedge clk);
      test_reset();
      test_exception();
      test_interrupt();
      test_delay_slot();
      test_priority();
      test_back_to_back();
      test_exlclr();
      test_sr_write();
      test_reset_mid_exc();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cp0_ctrl.md
CP0_CTRL -- requirements
Module: cp0_ctrl

Interface
REQ-001 SHALL expose parameter PRID_VAL, default 32'h2022_0707, value returned on reads of PRId (register 15).
REQ-002 SHALL have ports, one per line:
- clk  in  1  rising-edge clock, the only clock.
- reset  in  1  asynchronous, active-high reset.
- A1  in  5  mfc0 read register number.
- A2  in  5  mtc0 write register number.
- DIn  in  32  mtc0 write data.
- WE  in  1  mtc0 write enable (M stage).
- PC_M  in  32  PC of instruction in M stage.
- BD_M  in  1  M-stage instruction is in a branch delay slot.
- ExcCode_M  in  5  M-stage exception code; 0 = none.
- HWInt  in  6  hardware interrupt lines, level-sensitive.
- EXLClr  in  1  eret in M stage.
- Req  out  1  flush/redirect request to pipeline registers and PC.
- DOut  out  32  mfc0 read data.
- EPC_O  out  32  current EPC for eret redirect.

Function
REQ-003 SHALL hold SR(12): IM[15:10], EXL[1], IE[0]; all other SR bits read 0.
REQ-004 SHALL hold Cause(13): BD[31], IP[15:10], ExcCode[6:2]; other bits read 0.
REQ-005 SHALL hold EPC(14) as 32 bits with [1:0] always 0.
REQ-006 SHALL compute IntReq = (|(HWInt & SR.IM)) & SR.IE & ~SR.EXL, combinationally.
REQ-007 SHALL compute ExcReq = (ExcCode_M != 0) & ~SR.EXL, combinationally.
REQ-008 SHALL drive Req = (IntReq | ExcReq) & ~reset; zero-cycle latency from inputs.
REQ-009 SHALL, on a clk edge with Req=1: set SR.EXL=1; Cause.BD=BD_M; Cause.ExcCode = IntReq ? 0 : ExcCode_M; EPC = BD_M ? (PC_M-4) : PC_M, with [1:0] forced 0.
REQ-010 SHALL give interrupt priority over a simultaneous synchronous exception, per REQ-009.
REQ-011 SHALL sample Cause.IP <= HWInt on every clk edge, regardless of Req, WE or EXL.
REQ-012 SHALL clear SR.EXL on a clk edge with EXLClr=1 and Req=0.
REQ-013 SHALL, on a clk edge with WE=1 and Req=0, write as follows: A2=12 writes IM/EXL/IE from DIn; A2=14 writes EPC with {DIn[31:2],2'b00}; A2=13, 15 or any other value has no effect.
REQ-014 SHALL give Req priority over WE and EXLClr: a Req edge suppresses the write and the clear.
REQ-015 SHALL let EXLClr win the EXL bit when WE to SR and EXLClr coincide; IM/IE still take DIn.
REQ-016 SHALL drive DOut combinationally from A1: 12->SR, 13->Cause, 14->EPC, 15->PRID_VAL, others->0.
REQ-017 SHALL have DOut return the pre-edge value when the same register is written in the same cycle; there is no write-through.
REQ-018 SHALL drive EPC_O directly from the EPC register.
REQ-019 SHALL accept PC_M-4 wrapping modulo 2^32.

Reset
REQ-020 SHALL, while reset=1, asynchronously force SR=0, Cause=0 and EPC=0, and force Req=0.
REQ-021 SHALL, after reset deasserts, keep Req=0 until SR.IE=1 or ExcCode_M!=0.
REQ-022 SHALL, if reset asserts mid-exception (EXL=1), clear all state immediately; no EPC is retained.

Verification
REQ-023 Test: reset, then ExcCode_M=4, PC_M=32'h3010, BD_M=0 -> Req=1 same cycle; next edge EPC=32'h3010, ExcCode=4, EXL=1, Req drops to 0.
REQ-024 Test: SR written with 32'h0000_0401 via WE/A2=12, then HWInt=6'b000001 -> Req=1; edge gives ExcCode=0, IP[10]=1, EXL=1.
REQ-025 Test: BD_M=1, PC_M=32'h3004, ExcCode_M=10 -> EPC=32'h3000, Cause.BD=1.
REQ-026 Test: HWInt and ExcCode_M=12 active together with IE=1 and IM enabled -> ExcCode=0 latched (interrupt wins).
REQ-027 Test: WE=1, A2=14, DIn=32'h1237 with Req=1 in the same cycle -> EPC holds the exception PC and the write is dropped; WE alone -> EPC=32'h1234.
REQ-028 Test: EXL=1 and EXLClr=1 -> EXL=0 next edge; a pending enabled HWInt then raises Req in the following cycle.
